// File: rtl/key_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Package     : key_cmd_pkg
// Description : Shared constants and types for the keyboard-to-command path.
//               - PS/2 scan codes for the keys the game reacts to
//               - Movement FSM state encoding. The state value is driven
//                 straight onto key_state, so the encoding is part of the
//                 output interface: 10 = left, 01 = right, 00 = none.
//               - Small helpers used by the direction hand-off logic
// Revision    : 1.0 - initial release
// ============================================================================
package key_cmd_pkg;

    localparam logic [8:0] KEY_LEFT    = 9'h01C;   // A
    localparam logic [8:0] KEY_RIGHT   = 9'h023;   // D
    localparam logic [8:0] KEY_ENTER   = 9'h05A;   // main Enter
    localparam logic [8:0] KEY_ENTER_R = 9'h15A;   // keypad Enter (E0-prefixed)

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RIGHT = 2'b01,
        ST_LEFT  = 2'b10
    } state_t;

    // Opposite direction; only meaningful for ST_LEFT / ST_RIGHT.
    function automatic state_t other_dir(input state_t s);
        return (s == ST_LEFT) ? ST_RIGHT : ST_LEFT;
    endfunction

    // Scan code that holds a given direction; only meaningful for ST_LEFT / ST_RIGHT.
    function automatic logic [8:0] dir_code(input state_t s);
        return (s == ST_LEFT) ? KEY_LEFT : KEY_RIGHT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rate_tick.sv
`default_nettype none
// ============================================================================
// Module      : rate_tick
// Description : Free-running pacing counter for held-key movement.
//               The counter runs 0..MOVE_PERIOD-1 while 'run' is high and
//               wraps. 'clear' restarts it at 0. 'tick' is combinational and
//               is high on the clear cycle and on every wrap, so the caller
//               can register it alongside the state that caused the clear.
// Ports       : clk   - system clock
//               rst   - asynchronous active-low reset
//               clear - restart counting (direction change / disabled)
//               run   - count this cycle
//               tick  - step request (comb)
// Revision    : 1.0 - initial release
// ============================================================================
module rate_tick #(
    parameter int MOVE_PERIOD = 1_000_000,
    parameter int CNT_W       = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(MOVE_PERIOD - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = run && (r_cnt == C_LAST);
    assign tick   = clear || w_wrap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clear || w_wrap) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= r_cnt + C_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/key_cmd_gen.sv
`default_nettype none
// ============================================================================
// Module      : key_cmd_gen
// Description : Converts KeyboardDecoder output into game commands.
//               Tracks the held direction (last press wins, falls back to the
//               other direction key if it is still held), paces move ticks
//               while a direction is held, and emits one Enter pulse per
//               physical Enter press (typematic repeats are swallowed).
// Ports       : clk         - system clock
//               rst         - asynchronous active-low reset
//               key_down    - held-key bitmap indexed by scan code
//               last_change - scan code of the most recent make/break
//               key_valid   - 1-cycle strobe, key_down/last_change updated
//               enable      - 1 = game running, 0 = movement suppressed
//               key_state   - 10 left / 01 right / 00 none (registered)
//               move_tick   - 1-cycle step strobe (registered)
//               enter_pulse - 1-cycle Enter strobe (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module key_cmd_gen
    import key_cmd_pkg::*;
#(
    parameter int MOVE_PERIOD = 1_000_000,
    parameter int CNT_W       = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] key_down,
    input  logic [8:0]   last_change,
    input  logic         key_valid,
    input  logic         enable,
    output logic [1:0]   key_state,
    output logic         move_tick,
    output logic         enter_pulse
);

    state_t r_state;
    state_t w_next;
    state_t w_evt_dir;
    state_t w_fallback;
    logic   w_is_make;
    logic   w_is_dir;
    logic   w_is_enter;
    logic   w_clear;
    logic   w_run;
    logic   w_tick;
    logic   r_move_tick;
    logic   r_enter_held;
    logic   r_enter_pulse;

    assign w_is_make  = key_down[last_change];
    assign w_is_dir   = (last_change == KEY_LEFT) || (last_change == KEY_RIGHT);
    assign w_is_enter = (last_change == KEY_ENTER) || (last_change == KEY_ENTER_R);
    assign w_evt_dir  = (last_change == KEY_LEFT) ? ST_LEFT : ST_RIGHT;

    // Where the FSM goes when the current direction key is released:
    // the other direction if it is still down, otherwise idle.
    assign w_fallback = key_down[dir_code(other_dir(r_state))] ? other_dir(r_state) : ST_IDLE;

    // ------------------------------------------------------------------
    // Movement FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (!enable) begin
            w_next = ST_IDLE;
        end else if (key_valid) begin
            // Any decoder event this cycle wins over bitmap recovery.
            if (w_is_dir) begin
                if (w_is_make) begin
                    w_next = w_evt_dir;
                end else if (w_evt_dir == r_state) begin
                    w_next = w_fallback;
                end
            end
        end else begin
            // Recovery: resynchronise with the bitmap when an event was
            // missed (disabled period, reset, dropped break code).
            case (r_state)
                ST_LEFT, ST_RIGHT: begin
                    if (!key_down[dir_code(r_state)]) begin
                        w_next = w_fallback;
                    end
                end
                default: begin
                    if (key_down[KEY_LEFT]) begin
                        w_next = ST_LEFT;
                    end else if (key_down[KEY_RIGHT]) begin
                        w_next = ST_RIGHT;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Move pacing. The counter restarts on every state change so the
    // first step lands together with the new key_state value.
    // ------------------------------------------------------------------
    assign w_clear = !enable || (w_next != r_state);
    assign w_run   = (r_state != ST_IDLE);

    rate_tick #(
        .MOVE_PERIOD (MOVE_PERIOD),
        .CNT_W       (CNT_W)
    ) u_rate_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .run   (w_run),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_move_tick <= 1'b0;
        end else begin
            // A clear caused by going idle must not produce a step.
            r_move_tick <= w_tick && (w_next != ST_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Enter edge detection, independent of enable
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_enter_held  <= 1'b0;
            r_enter_pulse <= 1'b0;
        end else begin
            r_enter_pulse <= key_valid && w_is_enter && w_is_make && !r_enter_held;
            if (key_valid && w_is_enter) begin
                r_enter_held <= w_is_make;
            end
        end
    end

    assign key_state   = r_state;
    assign move_tick   = r_move_tick;
    assign enter_pulse = r_enter_pulse;

endmodule
`default_nettype wire

// File: tb/tb_key_cmd_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_cmd_gen
// Description : Directed scoreboard bench for key_cmd_gen (MOVE_PERIOD = 8).
//               Stimulus pushes the expected output events (cycle, key_state,
//               move_tick, enter_pulse) into a queue; a monitor on the
//               falling edge pops and compares whenever the DUT shows a tick,
//               a pulse or a key_state change.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_cmd_gen;

    localparam int P = 8;
    localparam logic [8:0] A   = 9'h01C;
    localparam logic [8:0] D   = 9'h023;
    localparam logic [8:0] ENT = 9'h05A;
    localparam logic [8:0] ENR = 9'h15A;
    localparam logic [1:0] L   = 2'b10;
    localparam logic [1:0] R   = 2'b01;
    localparam logic [1:0] N   = 2'b00;

    logic         clk;
    logic         rst;
    logic [511:0] key_down;
    logic [8:0]   last_change;
    logic         key_valid;
    logic         enable;
    logic [1:0]   key_state;
    logic         move_tick;
    logic         enter_pulse;

    typedef struct {
        int         cyc;
        logic [1:0] ks;
        logic       tick;
        logic       ent;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   tests  = 0;
    int   fails  = 0;
    int   n;

    key_cmd_gen #(
        .MOVE_PERIOD (P),
        .CNT_W       (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_down    (key_down),
        .last_change (last_change),
        .key_valid   (key_valid),
        .enable      (enable),
        .key_state   (key_state),
        .move_tick   (move_tick),
        .enter_pulse (enter_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before 100000");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    initial begin : monitor
        logic [1:0] prev_ks;
        exp_t       e;
        prev_ks = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_ks = key_state;
            end else if (move_tick || enter_pulse || (key_state != prev_ks)) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event: got cyc=%0d ks=%b tick=%b ent=%b, required no event",
                             cyc, key_state, move_tick, enter_pulse);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || e.ks != key_state || e.tick != move_tick || e.ent != enter_pulse) begin
                        fails++;
                        $display("FAIL event: got cyc=%0d ks=%b tick=%b ent=%b, required cyc=%0d ks=%b tick=%b ent=%b",
                                 cyc, key_state, move_tick, enter_pulse, e.cyc, e.ks, e.tick, e.ent);
                    end
                end
                prev_ks = key_state;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic push(input int c, input logic [1:0] ks, input logic t, input logic en);
        exp_t e;
        e.cyc = c; e.ks = ks; e.tick = t; e.ent = en;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) step();
    endtask

    task automatic make(input logic [8:0] code);
        key_down[code] = 1'b1;
        last_change    = code;
        key_valid      = 1'b1;
        step();
        key_valid      = 1'b0;
    endtask

    task automatic brk(input logic [8:0] code);
        key_down[code] = 1'b0;
        last_change    = code;
        key_valid      = 1'b1;
        step();
        key_valid      = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [1:0] got, input logic [1:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %b, required %b", nm, got, req);
        end
    endtask

    // Press, 3 typematic repeats, release, press, release: two pulses.
    task automatic enter_seq(input logic [8:0] code);
        n = cyc;
        push(n + 1, N, 1'b0, 1'b1);
        push(n + 6, N, 1'b0, 1'b1);
        make(code); make(code); make(code); make(code);
        brk(code);
        make(code);
        brk(code);
        idle(2);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        rst         = 1'b0;
        key_down    = '0;
        last_change = '0;
        key_valid   = 1'b0;
        enable      = 1'b1;
        #2;
        chk("reset_key_state",   key_state,          N);
        chk("reset_move_tick",   {1'b0, move_tick},  2'b00);
        chk("reset_enter_pulse", {1'b0, enter_pulse}, 2'b00);
        idle(2);
        rst = 1'b1;
        idle(2);

        // 1: hold A for 20 cycles -> ticks at +1, +9, +17, then idle
        n = cyc;
        push(n + 1,  L, 1'b1, 1'b0);
        push(n + 9,  L, 1'b1, 1'b0);
        push(n + 17, L, 1'b1, 1'b0);
        push(n + 21, N, 1'b0, 1'b0);
        make(A);
        idle(19);
        brk(A);
        idle(3);

        // 2: A, then D, release D -> back to A; counter restarts each change
        n = cyc;
        push(n + 1,  L, 1'b1, 1'b0);
        push(n + 6,  R, 1'b1, 1'b0);
        push(n + 9,  L, 1'b1, 1'b0);
        push(n + 17, L, 1'b1, 1'b0);
        push(n + 19, N, 1'b0, 1'b0);
        make(A);
        idle(4);
        make(D);
        idle(2);
        brk(D);
        idle(9);
        brk(A);
        idle(3);

        // 3: Enter pulses, both codes, also with movement disabled
        enter_seq(ENT);
        enter_seq(ENR);
        enable = 1'b0;
        enter_seq(ENT);
        enable = 1'b1;
        idle(2);

        // 4: disable while A held, ignored typematic, re-enable -> recovery
        n = cyc;
        push(n + 1, L, 1'b1, 1'b0);
        make(A);
        idle(2);
        enable = 1'b0;
        push(n + 4, N, 1'b0, 1'b0);
        step();
        make(A);
        idle(3);
        enable = 1'b1;
        push(n + 9, L, 1'b1, 1'b0);
        step();
        push(n + 10, N, 1'b0, 1'b0);
        brk(A);
        idle(3);

        // 5: A bit drops without an event -> idle next cycle, no tick
        n = cyc;
        push(n + 1, L, 1'b1, 1'b0);
        make(A);
        idle(3);
        key_down[A] = 1'b0;
        push(n + 5, N, 1'b0, 1'b0);
        step();
        idle(3);

        // 7: break of a non-current key is ignored; Enter pulse does not
        //    disturb direction pacing
        n = cyc;
        push(n + 1,  L, 1'b1, 1'b0);
        push(n + 2,  R, 1'b1, 1'b0);
        push(n + 3,  R, 1'b0, 1'b1);
        push(n + 10, R, 1'b1, 1'b0);
        push(n + 11, N, 1'b0, 1'b0);
        make(A);
        make(D);
        make(ENT);
        brk(A);
        idle(6);
        brk(D);
        brk(ENT);
        idle(3);

        // 6: async reset between edges while a tick is showing
        make(A);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_key_state",   key_state,           N);
        chk("async_rst_move_tick",   {1'b0, move_tick},   2'b00);
        chk("async_rst_enter_pulse", {1'b0, enter_pulse}, 2'b00);
        step();
        chk("held_rst_key_state", key_state, N);
        rst = 1'b1;
        n = cyc;
        push(n + 1, L, 1'b1, 1'b0);
        step();
        idle(2);
        push(n + 4, N, 1'b0, 1'b0);
        brk(A);
        idle(4);

        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL missing_events: got %0d events left in queue, required 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
